// File: rtl/instruction_utils.sv
// instruction_utils: shared RV32I definitions for the instruction encoder.
// Holds the instruction-type enum, the instruction-format enum, the
// opcode/funct3/funct7 field constants and the legal immediate ranges.
package instruction_utils;

    typedef enum logic [5:0] {
        INSTR_ILLEGAL, INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
        INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
        INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
        INSTR_SB, INSTR_SH, INSTR_SW,
        INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
        INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
        INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
        INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND
    } rv32i_instr_e;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} instr_format_e;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111, OPCODE_AUIPC  = 7'b0010111,
                           OPCODE_JAL    = 7'b1101111, OPCODE_JALR   = 7'b1100111,
                           OPCODE_BRANCH = 7'b1100011, OPCODE_LOAD   = 7'b0000011,
                           OPCODE_STORE  = 7'b0100011, OPCODE_OP_IMM = 7'b0010011,
                           OPCODE_OP     = 7'b0110011;

    localparam logic [2:0] FUNCT3_JALR = 3'b000,
                           FUNCT3_BEQ  = 3'b000, FUNCT3_BNE  = 3'b001, FUNCT3_BLT  = 3'b100,
                           FUNCT3_BGE  = 3'b101, FUNCT3_BLTU = 3'b110, FUNCT3_BGEU = 3'b111,
                           FUNCT3_LB   = 3'b000, FUNCT3_LH   = 3'b001, FUNCT3_LW   = 3'b010,
                           FUNCT3_LBU  = 3'b100, FUNCT3_LHU  = 3'b101,
                           FUNCT3_SB   = 3'b000, FUNCT3_SH   = 3'b001, FUNCT3_SW   = 3'b010,
                           FUNCT3_ADD  = 3'b000, FUNCT3_SLL  = 3'b001, FUNCT3_SLT  = 3'b010,
                           FUNCT3_SLTU = 3'b011, FUNCT3_XOR  = 3'b100, FUNCT3_SR   = 3'b101,
                           FUNCT3_OR   = 3'b110, FUNCT3_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000, FUNCT7_SUB  = 7'b0100000,
                           FUNCT7_SRA  = 7'b0100000, FUNCT7_SRAI = 7'b0100000;

    localparam int signed IMM12_MIN = -2048,    IMM12_MAX = 2047;
    localparam int signed SHAMT_MAX = 31;
    localparam int signed IMM_B_MIN = -4096,    IMM_B_MAX = 4094;
    localparam int signed IMM_J_MIN = -1048576, IMM_J_MAX = 1048574;

endpackage

// File: rtl/rv32i_encode_word.sv
// rv32i_encode_word: combinational packer from a decoded RV32I instruction
// to its 32-bit machine word.
//   instr_type, rd, rs1, rs2, imm : decoded instruction
//   word    : encoded word (0 for illegal types; out-of-range imm is truncated)
//   illegal : instr_type is not an encodable instruction
//   imm_err : immediate is outside the range its format can hold
module rv32i_encode_word
    import instruction_utils::*;
(
    input  rv32i_instr_e instr_type,
    input  logic [4:0]   rd,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [31:0]  imm,
    output logic [31:0]  word,
    output logic         illegal,
    output logic         imm_err
);
    instr_format_e      fmt;
    logic [6:0]         op, f7;
    logic [2:0]         f3;
    logic               shift, imm_ok;
    logic signed [31:0] simm;

    assign simm = imm;

    always_comb begin
        fmt = FMT_I; op = OPCODE_OP_IMM; f3 = FUNCT3_ADD; f7 = FUNCT7_BASE; shift = 1'b0; illegal = 1'b0;
        case (instr_type)
            INSTR_LUI:   begin fmt = FMT_U; op = OPCODE_LUI; end
            INSTR_AUIPC: begin fmt = FMT_U; op = OPCODE_AUIPC; end
            INSTR_JAL:   begin fmt = FMT_J; op = OPCODE_JAL; end
            INSTR_JALR:  begin op = OPCODE_JALR; f3 = FUNCT3_JALR; end
            INSTR_BEQ:   begin fmt = FMT_B; op = OPCODE_BRANCH; f3 = FUNCT3_BEQ; end
            INSTR_BNE:   begin fmt = FMT_B; op = OPCODE_BRANCH; f3 = FUNCT3_BNE; end
            INSTR_BLT:   begin fmt = FMT_B; op = OPCODE_BRANCH; f3 = FUNCT3_BLT; end
            INSTR_BGE:   begin fmt = FMT_B; op = OPCODE_BRANCH; f3 = FUNCT3_BGE; end
            INSTR_BLTU:  begin fmt = FMT_B; op = OPCODE_BRANCH; f3 = FUNCT3_BLTU; end
            INSTR_BGEU:  begin fmt = FMT_B; op = OPCODE_BRANCH; f3 = FUNCT3_BGEU; end
            INSTR_LB:    begin op = OPCODE_LOAD; f3 = FUNCT3_LB; end
            INSTR_LH:    begin op = OPCODE_LOAD; f3 = FUNCT3_LH; end
            INSTR_LW:    begin op = OPCODE_LOAD; f3 = FUNCT3_LW; end
            INSTR_LBU:   begin op = OPCODE_LOAD; f3 = FUNCT3_LBU; end
            INSTR_LHU:   begin op = OPCODE_LOAD; f3 = FUNCT3_LHU; end
            INSTR_SB:    begin fmt = FMT_S; op = OPCODE_STORE; f3 = FUNCT3_SB; end
            INSTR_SH:    begin fmt = FMT_S; op = OPCODE_STORE; f3 = FUNCT3_SH; end
            INSTR_SW:    begin fmt = FMT_S; op = OPCODE_STORE; f3 = FUNCT3_SW; end
            INSTR_ADDI:  f3 = FUNCT3_ADD;
            INSTR_SLTI:  f3 = FUNCT3_SLT;
            INSTR_SLTIU: f3 = FUNCT3_SLTU;
            INSTR_XORI:  f3 = FUNCT3_XOR;
            INSTR_ORI:   f3 = FUNCT3_OR;
            INSTR_ANDI:  f3 = FUNCT3_AND;
            INSTR_SLLI:  begin f3 = FUNCT3_SLL; shift = 1'b1; end
            INSTR_SRLI:  begin f3 = FUNCT3_SR; shift = 1'b1; end
            INSTR_SRAI:  begin f3 = FUNCT3_SR; f7 = FUNCT7_SRAI; shift = 1'b1; end
            INSTR_ADD:   begin fmt = FMT_R; op = OPCODE_OP; f3 = FUNCT3_ADD; end
            INSTR_SUB:   begin fmt = FMT_R; op = OPCODE_OP; f3 = FUNCT3_ADD; f7 = FUNCT7_SUB; end
            INSTR_SLL:   begin fmt = FMT_R; op = OPCODE_OP; f3 = FUNCT3_SLL; end
            INSTR_SLT:   begin fmt = FMT_R; op = OPCODE_OP; f3 = FUNCT3_SLT; end
            INSTR_SLTU:  begin fmt = FMT_R; op = OPCODE_OP; f3 = FUNCT3_SLTU; end
            INSTR_XOR:   begin fmt = FMT_R; op = OPCODE_OP; f3 = FUNCT3_XOR; end
            INSTR_SRL:   begin fmt = FMT_R; op = OPCODE_OP; f3 = FUNCT3_SR; end
            INSTR_SRA:   begin fmt = FMT_R; op = OPCODE_OP; f3 = FUNCT3_SR; f7 = FUNCT7_SRA; end
            INSTR_OR:    begin fmt = FMT_R; op = OPCODE_OP; f3 = FUNCT3_OR; end
            INSTR_AND:   begin fmt = FMT_R; op = OPCODE_OP; f3 = FUNCT3_AND; end
            default:     illegal = 1'b1;
        endcase
    end

    assign imm_ok = (fmt == FMT_I && shift)        ? imm <= 32'(SHAMT_MAX)
                  : (fmt == FMT_I || fmt == FMT_S) ? (simm >= IMM12_MIN && simm <= IMM12_MAX)
                  : fmt == FMT_B ? (!imm[0] && simm >= IMM_B_MIN && simm <= IMM_B_MAX)
                  : fmt == FMT_J ? (!imm[0] && simm >= IMM_J_MIN && simm <= IMM_J_MAX)
                  : fmt == FMT_U ? imm[11:0] == 12'd0
                  : 1'b1;

    assign imm_err = !illegal && !imm_ok;

    assign word = illegal                  ? 32'h0000_0000
                : fmt == FMT_R             ? {f7, rs2, rs1, f3, rd, op}
                : (fmt == FMT_I && shift)  ? {f7, imm[4:0], rs1, f3, rd, op}
                : fmt == FMT_I             ? {imm[11:0], rs1, f3, rd, op}
                : fmt == FMT_S             ? {imm[11:5], rs2, rs1, f3, imm[4:0], op}
                : fmt == FMT_B             ? {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
                : fmt == FMT_U             ? {imm[31:12], rd, op}
                : {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams decoded RV32I instructions into instruction memory
// as encoded words at consecutive word addresses, flagging bad input.
//   clk, rst                  : clock, synchronous active-high reset
//   start                     : begin a program (clears address and errors)
//   in_valid/in_ready         : instruction handshake; in_type, in_rd, in_rs1,
//                               in_rs2, in_imm, in_last describe the instruction
//   mem_we/mem_ready          : write handshake; mem_addr, mem_wdata held until taken
//   done                      : program finished
//   err_illegal/err_imm/err_full : sticky error flags
//   err_addr                  : address of the first word flagged illegal or bad-imm
module instr_encoder
    import instruction_utils::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  rv32i_instr_e      in_type,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err_illegal,
    output logic              err_imm,
    output logic              err_full,
    output logic [ADDR_W-1:0] err_addr
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    state_e            state;
    logic              drain, last_q, ill_q, imm_q;
    logic              wr_done, accept;
    logic [ADDR_W-1:0] accept_addr;
    logic [31:0]       enc_word;
    logic              enc_illegal, enc_imm_err;

    rv32i_encode_word u_encode (
        .instr_type (in_type),
        .rd         (in_rd),
        .rs1        (in_rs1),
        .rs2        (in_rs2),
        .imm        (in_imm),
        .word       (enc_word),
        .illegal    (enc_illegal),
        .imm_err    (enc_imm_err)
    );

    assign in_ready = state == S_RUN && !drain && (!mem_we || mem_ready);
    assign wr_done  = mem_we && mem_ready;
    assign accept   = in_valid && in_ready;
    // A word accepted while the previous one completes lands one address higher.
    assign accept_addr = mem_addr + ADDR_W'(wr_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE; drain <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
            last_q <= 1'b0; ill_q <= 1'b0; imm_q <= 1'b0; done <= 1'b0;
            err_illegal <= 1'b0; err_imm <= 1'b0; err_full <= 1'b0; err_addr <= '0;
        end else if (start) begin
            state <= S_RUN; drain <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
            last_q <= 1'b0; ill_q <= 1'b0; imm_q <= 1'b0; done <= 1'b0;
            err_illegal <= 1'b0; err_imm <= 1'b0; err_full <= 1'b0; err_addr <= '0;
        end else begin
            if (wr_done) begin
                mem_addr    <= mem_addr + 1'b1;
                err_illegal <= err_illegal | ill_q;
                err_imm     <= err_imm | imm_q;
                if (!err_illegal && !err_imm && (ill_q || imm_q))
                    err_addr <= mem_addr;
                if (last_q || mem_addr == TOP_ADDR) begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    err_full <= err_full | !last_q;
                end
            end
            if (accept) begin
                mem_we    <= 1'b1;
                mem_wdata <= enc_word;
                ill_q     <= enc_illegal;
                imm_q     <= enc_imm_err;
                last_q    <= in_last;
                drain     <= in_last || accept_addr == TOP_ADDR;
            end else if (wr_done) begin
                mem_we <= 1'b0;
            end
        end
    end

endmodule
